// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline: ALU function codes,
// operand forward-select codes and default datapath widths.
package mips_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int REGW_DEF  = 5;

   // ALU F input encoding
   typedef enum logic [2:0] {
      F_AND  = 3'b000,
      F_OR   = 3'b001,
      F_ADD  = 3'b010,
      F_ANDN = 3'b100,
      F_ORN  = 3'b101,
      F_SUB  = 3'b110,
      F_SLT  = 3'b111
   } alu_f_t;

   // Operand source selected by the forwarding unit
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forward-select generator for one E-stage source operand.
// Only present when EX_FORWARD_EN is defined; the default build has no
// forwarding and never instantiates this module.
`ifdef EX_FORWARD_EN
module fwd_unit
   import mips_pkg::*;
#(
   parameter int REGW = REGW_DEF
) (
   input  logic [REGW-1:0] src,
   input  logic [REGW-1:0] writeregM,
   input  logic            regwriteM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwriteW,
   output fwd_sel_t        sel
);

   // MEM result is the youngest so it wins over WB; register 0 never forwards
   always_comb begin
      sel = FWD_RF;
      if (src != '0) begin
         if (regwriteM && (writeregM == src)) begin
            sel = FWD_M;
         end else if (regwriteW && (writeregW == src)) begin
            sel = FWD_W;
         end
      end
   end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus ALU operand selection.
// Optional feature macro: EX_FORWARD_EN -- when defined, source operands are
// forwarded from MEM/WB; when undefined, operands come straight from the
// register file values captured in E and the M/W inputs are ignored.
// Pipeline control: flushE loads a bubble (all zero, so it never writes and
// never forwards) and beats stallE; stallE holds every E register.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int REGW  = REGW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stallE,
   input  logic             flushE,
   input  logic             regwriteD,
   input  logic             memtoregD,
   input  logic             memwriteD,
   input  logic             alusrcD,
   input  logic             regdstD,
   input  logic [2:0]       alucontrolD,
   input  logic [WIDTH-1:0] rd1D,
   input  logic [WIDTH-1:0] rd2D,
   input  logic [WIDTH-1:0] signimmD,
   input  logic [REGW-1:0]  rsD,
   input  logic [REGW-1:0]  rtD,
   input  logic [REGW-1:0]  rdD,
   input  logic [WIDTH-1:0] aluoutM,
   input  logic [REGW-1:0]  writeregM,
   input  logic             regwriteM,
   input  logic [WIDTH-1:0] resultW,
   input  logic [REGW-1:0]  writeregW,
   input  logic             regwriteW,
   output logic [WIDTH-1:0] srcAE,
   output logic [WIDTH-1:0] srcBE,
   output logic [2:0]       alucontrolE,
   output logic [WIDTH-1:0] writedataE,
   output logic [REGW-1:0]  writeregE,
   output logic             regwriteE,
   output logic             memtoregE,
   output logic             memwriteE,
   output logic [REGW-1:0]  rsE,
   output logic [REGW-1:0]  rtE
);

   logic             alusrcE;
   logic             regdstE;
   logic [WIDTH-1:0] rd1E;
   logic [WIDTH-1:0] rd2E;
   logic [WIDTH-1:0] signimmE;
   logic [REGW-1:0]  rdE;

   // E-stage register: reset, then flush (bubble), then stall (hold), else load
   always_ff @(posedge clk) begin
      if (reset || flushE) begin
         regwriteE   <= 1'b0;
         memtoregE   <= 1'b0;
         memwriteE   <= 1'b0;
         alusrcE     <= 1'b0;
         regdstE     <= 1'b0;
         alucontrolE <= F_AND;
         rd1E        <= '0;
         rd2E        <= '0;
         signimmE    <= '0;
         rsE         <= '0;
         rtE         <= '0;
         rdE         <= '0;
      end else if (!stallE) begin
         regwriteE   <= regwriteD;
         memtoregE   <= memtoregD;
         memwriteE   <= memwriteD;
         alusrcE     <= alusrcD;
         regdstE     <= regdstD;
         alucontrolE <= alucontrolD;
         rd1E        <= rd1D;
         rd2E        <= rd2D;
         signimmE    <= signimmD;
         rsE         <= rsD;
         rtE         <= rtD;
         rdE         <= rdD;
      end
   end

`ifdef EX_FORWARD_EN
   fwd_sel_t sel_a;
   fwd_sel_t sel_b;

   fwd_unit #(.REGW(REGW)) u_fwd_a (
      .src       (rsE),
      .writeregM (writeregM),
      .regwriteM (regwriteM),
      .writeregW (writeregW),
      .regwriteW (regwriteW),
      .sel       (sel_a)
   );

   fwd_unit #(.REGW(REGW)) u_fwd_b (
      .src       (rtE),
      .writeregM (writeregM),
      .regwriteM (regwriteM),
      .writeregW (writeregW),
      .regwriteW (regwriteW),
      .sel       (sel_b)
   );

   // Forwarding muxes for the A operand and the store-data / B operand
   always_comb begin
      srcAE      = rd1E;
      writedataE = rd2E;
      case (sel_a)
         FWD_M:   srcAE = aluoutM;
         FWD_W:   srcAE = resultW;
         default: srcAE = rd1E;
      endcase
      case (sel_b)
         FWD_M:   writedataE = aluoutM;
         FWD_W:   writedataE = resultW;
         default: writedataE = rd2E;
      endcase
   end
`else
   // Without forwarding the pipeline relies on stalls; M/W inputs are unused
   logic unused_fwd;
   assign unused_fwd = ^{aluoutM, writeregM, regwriteM,
                         resultW, writeregW, regwriteW};

   assign srcAE      = rd1E;
   assign writedataE = rd2E;
`endif

   // B operand: immediate or (possibly forwarded) rt value
   assign srcBE = alusrcE ? signimmE : writedataE;

   // Destination register: rd for R-type, rt otherwise
   assign writeregE = regdstE ? rdE : rtE;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomised test of id_ex_stage with a reference model and an
// expected-value queue. Expectations follow EX_FORWARD_EN the same way the
// design is built.
module tb_id_ex_stage;

   localparam int WIDTH = 32;
   localparam int REGW  = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic             stallE, flushE;
   logic             regwriteD, memtoregD, memwriteD, alusrcD, regdstD;
   logic [2:0]       alucontrolD;
   logic [WIDTH-1:0] rd1D, rd2D, signimmD;
   logic [REGW-1:0]  rsD, rtD, rdD;
   logic [WIDTH-1:0] aluoutM, resultW;
   logic [REGW-1:0]  writeregM, writeregW;
   logic             regwriteM, regwriteW;
   logic [WIDTH-1:0] srcAE, srcBE, writedataE;
   logic [2:0]       alucontrolE;
   logic [REGW-1:0]  writeregE, rsE, rtE;
   logic             regwriteE, memtoregE, memwriteE;

   id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
      .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
      .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
      .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
      .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
      .rsD(rsD), .rtD(rtD), .rdD(rdD),
      .aluoutM(aluoutM), .writeregM(writeregM), .regwriteM(regwriteM),
      .resultW(resultW), .writeregW(writeregW), .regwriteW(regwriteW),
      .srcAE(srcAE), .srcBE(srcBE), .alucontrolE(alucontrolE),
      .writedataE(writedataE), .writeregE(writeregE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
      .rsE(rsE), .rtE(rtE)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] wdata;
      logic [2:0]       alu;
      logic [REGW-1:0]  wreg;
      logic             rw;
      logic             mtr;
      logic             mw;
      logic [REGW-1:0]  rs;
      logic [REGW-1:0]  rt;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   // model of the E-stage registers
   logic             m_rw, m_mtr, m_mw, m_alusrc, m_regdst;
   logic [2:0]       m_alu;
   logic [WIDTH-1:0] m_rd1, m_rd2, m_imm;
   logic [REGW-1:0]  m_rs, m_rt, m_rd;

   function automatic logic [WIDTH-1:0] fwd(input logic [REGW-1:0] r,
                                            input logic [WIDTH-1:0] rf);
`ifdef EX_FORWARD_EN
      if (r != 0 && regwriteM && writeregM == r) return aluoutM;
      if (r != 0 && regwriteW && writeregW == r) return resultW;
`endif
      return rf;
   endfunction

   task automatic cmp(input string tag, input logic [WIDTH-1:0] act,
                      input logic [WIDTH-1:0] exp);
      tests_run++;
      assert (act === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   // advance model, push expected outputs, clock, then pop and compare
   task automatic step(input string tag);
      exp_t e;
      exp_t got;
      if (reset || flushE) begin
         {m_rw, m_mtr, m_mw, m_alusrc, m_regdst} = '0;
         m_alu = 3'b000;
         m_rd1 = '0; m_rd2 = '0; m_imm = '0;
         m_rs = '0; m_rt = '0; m_rd = '0;
      end else if (!stallE) begin
         m_rw = regwriteD; m_mtr = memtoregD; m_mw = memwriteD;
         m_alusrc = alusrcD; m_regdst = regdstD; m_alu = alucontrolD;
         m_rd1 = rd1D; m_rd2 = rd2D; m_imm = signimmD;
         m_rs = rsD; m_rt = rtD; m_rd = rdD;
      end
      e.src_a = fwd(m_rs, m_rd1);
      e.wdata = fwd(m_rt, m_rd2);
      e.src_b = m_alusrc ? m_imm : e.wdata;
      e.alu   = m_alu;
      e.wreg  = m_regdst ? m_rd : m_rt;
      e.rw    = m_rw;
      e.mtr   = m_mtr;
      e.mw    = m_mw;
      e.rs    = m_rs;
      e.rt    = m_rt;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      got = exp_t'(exp_q.pop_front());
      cmp({tag, ".srcAE"},       srcAE,                got.src_a);
      cmp({tag, ".srcBE"},       srcBE,                got.src_b);
      cmp({tag, ".writedataE"},  writedataE,           got.wdata);
      cmp({tag, ".alucontrolE"}, 32'(alucontrolE),     32'(got.alu));
      cmp({tag, ".writeregE"},   32'(writeregE),       32'(got.wreg));
      cmp({tag, ".ctrlE"}, 32'({regwriteE, memtoregE, memwriteE}),
          32'({got.rw, got.mtr, got.mw}));
      cmp({tag, ".rsE"},         32'(rsE),             32'(got.rs));
      cmp({tag, ".rtE"},         32'(rtE),             32'(got.rt));
   endtask

   task automatic set_d(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] imm, input logic [2:0] f,
                        input logic src, input logic dst,
                        input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                        input logic [REGW-1:0] rd);
      rd1D = a; rd2D = b; signimmD = imm; alucontrolD = f;
      alusrcD = src; regdstD = dst; rsD = rs; rtD = rt; rdD = rd;
      regwriteD = 1'b1; memtoregD = 1'b0; memwriteD = 1'b0;
   endtask

   task automatic set_mw(input logic [REGW-1:0] wm, input logic em,
                         input logic [WIDTH-1:0] vm,
                         input logic [REGW-1:0] ww, input logic ew,
                         input logic [WIDTH-1:0] vw);
      writeregM = wm; regwriteM = em; aluoutM = vm;
      writeregW = ww; regwriteW = ew; resultW = vw;
   endtask

   task automatic rand_d();
      rd1D = $urandom; rd2D = $urandom; signimmD = $urandom;
      alucontrolD = 3'($urandom_range(0, 7));
      {regwriteD, memtoregD, memwriteD, alusrcD, regdstD} = 5'($urandom_range(0, 31));
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rdD = 5'($urandom_range(0, 31));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      reset = 1'b1; stallE = 1'b0; flushE = 1'b0;
      set_d(32'hAAAA_0001, 32'hBBBB_0002, 32'h1234, 3'b111, 1'b1, 1'b1, 5'd7, 5'd8, 5'd9);
      memwriteD = 1'b1; memtoregD = 1'b1;
      set_mw(5'd7, 1'b1, 32'hDEAD, 5'd8, 1'b1, 32'hBEEF);
      #2;
      step("reset0");
      step("reset1");
      reset = 1'b0;

      // plain capture, no hazards
      set_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_d(32'd5, 32'd7, 32'h0, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
      step("capture_reg");
      set_d(32'd5, 32'd7, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      step("capture_imm");

      // forward priority on A, W forwarding on B
      set_d(32'h100, 32'h200, 32'h0, 3'b110, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
      set_mw(5'd3, 1'b1, 32'h11, 5'd3, 1'b1, 32'h22);
      step("fwd_m_over_w");
      regwriteM = 1'b0;
      #1 cmp("fwd_w_comb", srcAE, fwd(5'd3, 32'h100));
      step("fwd_w");
      writeregW = 5'd4;
      #1 cmp("fwd_b_w", writedataE, fwd(5'd4, 32'h200));
      set_d(32'h300, 32'h400, 32'h0, 3'b001, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6);
      set_mw(5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22);
      step("fwd_r0");

      // stall for three cycles while D changes
      set_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_d(32'h55, 32'h66, 32'h77, 3'b101, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12);
      memwriteD = 1'b1;
      step("pre_stall");
      stallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_d();
         step("stall");
      end
      // flush beats stall
      flushE = 1'b1;
      rand_d();
      step("flush_stall");
      stallE = 1'b0; flushE = 1'b0;

      // destination select
      set_d(32'h1, 32'h2, 32'h3, 3'b000, 1'b0, 1'b0, 5'd1, 5'd8, 5'd9);
      step("dst_rt");
      set_d(32'h1, 32'h2, 32'h3, 3'b000, 1'b0, 1'b1, 5'd1, 5'd8, 5'd9);
      step("dst_rd");

      // reset in mid-stream
      rand_d();
      step("pre_reset");
      reset = 1'b1;
      rand_d();
      step("mid_reset");
      reset = 1'b0;

      // randomised hazards, stalls and flushes
      for (int i = 0; i < 40; i++) begin
         rand_d();
         set_mw(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         stallE = ($urandom_range(0, 3) == 0);
         flushE = ($urandom_range(0, 7) == 0);
         step("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
